// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address helpers for the text LCD receiver.
package lcd_pkg;

    // DDRAM geometry: two 40-character lines at 0x00 and 0x40.
    localparam logic [6:0] LINE1_END   = 7'h27;
    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [6:0] LINE2_END   = 7'h67;
    localparam logic [7:0] SPACE       = 8'h20;
    localparam int         LINE_LEN    = 40;
    localparam int         DDRAM_DEPTH = 80;

    // Instruction class masks; the highest set bit selects the instruction.
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IDLE  = 2'd2
    } lcd_state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPCTL,
        OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
    } lcd_op_e;

    // Priority decode of an instruction byte.
    function automatic lcd_op_e decode_op(input logic [7:0] d);
        if ((d & CMD_DDRAM) != 8'h00)        return OP_DDRAM;
        else if ((d & CMD_CGRAM) != 8'h00)   return OP_CGRAM;
        else if ((d & CMD_FUNC) != 8'h00)    return OP_FUNC;
        else if ((d & CMD_SHIFT) != 8'h00)   return OP_SHIFT;
        else if ((d & CMD_DISPCTL) != 8'h00) return OP_DISPCTL;
        else if ((d & CMD_ENTRY) != 8'h00)   return OP_ENTRY;
        else if ((d & CMD_HOME) != 8'h00)    return OP_HOME;
        else if ((d & CMD_CLEAR) != 8'h00)   return OP_CLEAR;
        else                                 return OP_NOP;
    endfunction

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
    endfunction

    // Map a valid DDRAM address to a storage index 0..79.
    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        return a[6] ? (a - LINE2_BASE + 7'(LINE_LEN)) : a;
    endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next DDRAM address for a one-position move, wrapping between the two lines.
module lcd_addr_step
    import lcd_pkg::*;
(
    input  logic [6:0] addr_i,
    input  logic       dir_i,
    output logic [6:0] addr_o
);

    // dir_i = 1 moves right (increment), 0 moves left (decrement).
    always_comb begin
        addr_o = addr_i;
        if (dir_i) begin
            if (addr_i == LINE1_END)      addr_o = LINE2_BASE;
            else if (addr_i == LINE2_END) addr_o = 7'h00;
            else                          addr_o = addr_i + 7'd1;
        end else begin
            if (addr_i == LINE2_BASE)     addr_o = LINE1_END;
            else if (addr_i == 7'h00)     addr_o = LINE2_END;
            else                          addr_o = addr_i - 7'd1;
        end
    end

endmodule

// File: rtl/text_lcd_receiver.sv
// Responder-side HD44780-style character LCD: bus sync, decode, DDRAM and busy timing.
module text_lcd_receiver
    import lcd_pkg::*;
#(
    parameter int CMD_CYCLES   = 40,
    parameter int CLEAR_CYCLES = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] addr_cnt,
    output logic       inc_mode,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [2:0] func_bits,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       cmd_dropped,
    output logic       bad_addr,
    output lcd_state_e dbg_state
);

    localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

    // Bus handshake: the driver sets RS/RW/DATA, raises E, and the access
    // takes effect on the falling edge of E seen through the synchronizer.
    logic       e_s1_q, e_s2_q, rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       addr_q, addr_d;
    logic             inc_q, inc_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic [2:0]       func_q, func_d;
    logic             drop_q, drop_d, bad_q, bad_d;
    logic [7:0]       dout_q, rd_char_q;
    logic             oe_q;

    logic [7:0] ddram_q [DDRAM_DEPTH];
    logic       ram_we;
    logic [6:0] ram_idx;
    logic [7:0] ram_wdata;

    logic       strobe, bf_read, step_dir;
    logic [6:0] step_addr;
    lcd_op_e    op;

    assign strobe   = e_s2_q & ~e_s1_q;
    assign bf_read  = ~rs_s2_q & rw_s2_q;
    assign op       = decode_op(data_s2_q);
    assign step_dir = (!rs_s2_q && (op == OP_SHIFT)) ? data_s2_q[2] : inc_q;
    assign busy     = (state_q != ST_IDLE);

    lcd_addr_step u_step (
        .addr_i (addr_q),
        .dir_i  (step_dir),
        .addr_o (step_addr)
    );

    // Two-stage synchronizer for the asynchronous bus inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_s1_q <= 1'b0; e_s2_q <= 1'b0; rs_s1_q <= 1'b0; rs_s2_q <= 1'b0;
            rw_s1_q <= 1'b0; rw_s2_q <= 1'b0; data_s1_q <= 8'h00; data_s2_q <= 8'h00;
        end else begin
            e_s1_q <= lcd_e;   e_s2_q <= e_s1_q;
            rs_s1_q <= lcd_rs; rs_s2_q <= rs_s1_q;
            rw_s1_q <= lcd_rw; rw_s2_q <= rw_s1_q;
            data_s1_q <= lcd_data_in; data_s2_q <= data_s1_q;
        end
    end

    // Next-state: busy timing, DDRAM fill during clear, and access execution.
    always_comb begin
        state_d = state_q; cnt_d = cnt_q; addr_d = addr_q; inc_d = inc_q;
        disp_d = disp_q; cur_d = cur_q; blink_d = blink_q; func_d = func_q;
        drop_d = 1'b0; bad_d = 1'b0;
        ram_we = 1'b0; ram_idx = 7'd0; ram_wdata = SPACE;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q < CNT_W'(DDRAM_DEPTH)) begin
                    ram_we  = 1'b1;
                    ram_idx = cnt_q[6:0];
                end
                if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_IDLE; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_W'(CMD_CYCLES - 1)) begin
                    state_d = ST_IDLE; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Busy-flag reads only drive lcd_data_out and never touch state.
        if (strobe && !bf_read) begin
            if (state_q != ST_IDLE) begin
                drop_d = 1'b1;
            end else begin
                state_d = ST_EXEC;
                cnt_d   = '0;
                if (rs_s2_q) begin
                    if (!rw_s2_q) begin
                        ram_we    = 1'b1;
                        ram_idx   = addr_to_idx(addr_q);
                        ram_wdata = data_s2_q;
                    end
                    addr_d = step_addr;
                end else begin
                    case (op)
                        OP_CLEAR:   begin addr_d = 7'h00; inc_d = 1'b1; state_d = ST_CLEAR; end
                        OP_HOME:    addr_d = 7'h00;
                        OP_ENTRY:   inc_d = data_s2_q[1];
                        OP_DISPCTL: {disp_d, cur_d, blink_d} = data_s2_q[2:0];
                        OP_SHIFT:   if (!data_s2_q[3]) addr_d = step_addr;
                        OP_FUNC:    func_d = data_s2_q[4:2];
                        OP_DDRAM: begin
                            if (addr_valid(data_s2_q[6:0])) begin
                                addr_d = data_s2_q[6:0];
                            end else begin
                                addr_d = 7'h00; bad_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Control registers; reset restarts the clear sequence from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR; cnt_q <= '0; addr_q <= 7'h00; inc_q <= 1'b1;
            disp_q <= 1'b0; cur_q <= 1'b0; blink_q <= 1'b0; func_q <= 3'b000;
            drop_q <= 1'b0; bad_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; addr_q <= addr_d; inc_q <= inc_d;
            disp_q <= disp_d; cur_q <= cur_d; blink_q <= blink_d; func_q <= func_d;
            drop_q <= drop_d; bad_q <= bad_d;
        end
    end

    // DDRAM storage; no reset because the clear sequence refills it.
    always_ff @(posedge clk) begin
        if (ram_we) ddram_q[ram_idx] <= ram_wdata;
    end

    // Registered bus read data, output enable and host read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= 8'h00; oe_q <= 1'b0; rd_char_q <= SPACE;
        end else begin
            dout_q    <= rs_s2_q ? ddram_q[addr_to_idx(addr_q)] : {busy, addr_q};
            oe_q      <= rw_s2_q & e_s2_q;
            rd_char_q <= addr_valid(rd_addr) ? ddram_q[addr_to_idx(rd_addr)] : SPACE;
        end
    end

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign addr_cnt     = addr_q;
    assign inc_mode     = inc_q;
    assign disp_on      = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blink_q;
    assign func_bits    = func_q;
    assign rd_char      = rd_char_q;
    assign cmd_dropped  = drop_q;
    assign bad_addr     = bad_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_text_lcd_receiver.sv
// Directed bench for text_lcd_receiver: bus accesses with hand-computed expectations.
module tb_text_lcd_receiver;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, busy, inc_mode, disp_on, cursor_on, blink_on;
    logic [6:0] addr_cnt;
    logic [2:0] func_bits;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_char;
    logic       cmd_dropped, bad_addr;
    lcd_state_e dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int drop_cnt = 0;
    int bad_cnt  = 0;
    int n;

    logic [7:0] msg [7];

    text_lcd_receiver #(.CMD_CYCLES(40), .CLEAR_CYCLES(160)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .addr_cnt(addr_cnt), .inc_mode(inc_mode), .disp_on(disp_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .func_bits(func_bits),
        .rd_addr(rd_addr), .rd_char(rd_char), .cmd_dropped(cmd_dropped),
        .bad_addr(bad_addr), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_dropped) drop_cnt++;
        if (bad_addr) bad_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Raise E with RS/RW/DATA set; after three cycles the read data is registered.
    task automatic bus_start(input logic rs, input logic rw, input logic [7:0] d);
        step(1);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
        step(3);
    endtask

    // Drop E; after three cycles the strobe has been executed.
    task automatic bus_end();
        lcd_e = 1'b0;
        step(3);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            step(1);
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic access(input logic rs, input logic [7:0] d);
        bus_start(rs, 1'b0, d);
        bus_end();
        wait_idle("idle_wait");
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        step(1);
        check(tag, {24'd0, rd_char}, {24'd0, exp});
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 1000) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        msg[0] = 8'h44; msg[1] = 8'h69; msg[2] = 8'h67; msg[3] = 8'h69;
        msg[4] = 8'h74; msg[5] = 8'h61; msg[6] = 8'h6C;

        // 1. Reset values, then the power-up clear
        step(2);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_state", 32'(dbg_state), 32'(ST_CLEAR));
        check("rst_rd_char", {24'd0, rd_char}, 32'h20);
        check("rst_dout", {24'd0, lcd_data_out}, 32'h00);
        check("rst_oe", {31'd0, lcd_data_oe}, 32'd0);
        check("rst_drop", {31'd0, cmd_dropped}, 32'd0);
        rst = 1'b0;
        count_busy(n);
        check("init_busy_len", n, 160);
        rd_chk("init_00", 7'h00, 8'h20);
        rd_chk("init_27", 7'h27, 8'h20);
        rd_chk("init_40", 7'h40, 8'h20);
        rd_chk("init_67", 7'h67, 8'h20);
        rd_chk("init_invalid", 7'h30, 8'h20);
        check("init_addr", {25'd0, addr_cnt}, 32'h00);
        check("init_inc", {31'd0, inc_mode}, 32'd1);

        // 2. Setup and a string on line 1
        access(1'b0, 8'h3C);
        access(1'b0, 8'h06);
        access(1'b0, 8'h0C);
        access(1'b0, 8'h80);
        for (int i = 0; i < 7; i++) access(1'b1, msg[i]);
        for (int i = 0; i < 7; i++) rd_chk("msg_char", 7'(i), msg[i]);
        check("msg_addr", {25'd0, addr_cnt}, 32'h07);
        check("disp_on", {31'd0, disp_on}, 32'd1);
        check("cursor_on", {31'd0, cursor_on}, 32'd0);
        check("blink_on", {31'd0, blink_on}, 32'd0);
        check("func_bits", {29'd0, func_bits}, 32'h7);

        // 3. Line wrap in both directions, cursor moves, ignored instructions
        access(1'b0, 8'hA7);
        check("set_27", {25'd0, addr_cnt}, 32'h27);
        access(1'b1, 8'h41);
        rd_chk("wr_27", 7'h27, 8'h41);
        check("wrap_27_40", {25'd0, addr_cnt}, 32'h40);
        access(1'b0, 8'hE7);
        access(1'b1, 8'h42);
        rd_chk("wr_67", 7'h67, 8'h42);
        check("wrap_67_00", {25'd0, addr_cnt}, 32'h00);
        access(1'b0, 8'h10);
        check("cur_left_00", {25'd0, addr_cnt}, 32'h67);
        access(1'b0, 8'h14);
        check("cur_right_67", {25'd0, addr_cnt}, 32'h00);
        access(1'b0, 8'h04);
        check("dec_mode", {31'd0, inc_mode}, 32'd0);
        access(1'b0, 8'h80);
        access(1'b1, 8'h43);
        rd_chk("wr_00", 7'h00, 8'h43);
        check("dec_wrap_00", {25'd0, addr_cnt}, 32'h67);
        access(1'b0, 8'hC0);
        access(1'b1, 8'h44);
        rd_chk("wr_40", 7'h40, 8'h44);
        check("dec_wrap_40", {25'd0, addr_cnt}, 32'h27);
        access(1'b0, 8'h18);
        check("disp_shift_ign", {25'd0, addr_cnt}, 32'h27);
        access(1'b0, 8'h40);
        check("cgram_ign", {25'd0, addr_cnt}, 32'h27);
        access(1'b0, 8'h02);
        check("home", {25'd0, addr_cnt}, 32'h00);

        // 4. Clear: dropped write, busy-flag read during clear
        bus_start(1'b0, 1'b0, 8'h01);
        bus_end();
        check("clr_busy", {31'd0, busy}, 32'd1);
        step(8);
        bus_start(1'b1, 1'b0, 8'h55);
        bus_end();
        check("clr_drop", drop_cnt, 1);
        bus_start(1'b0, 1'b1, 8'h00);
        check("bf_read_dout", {24'd0, lcd_data_out}, 32'h80);
        check("bf_read_oe", {31'd0, lcd_data_oe}, 32'd1);
        bus_end();
        check("bf_no_drop", drop_cnt, 1);
        wait_idle("clr_idle");
        for (int a = 0; a < 128; a++) begin
            if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) rd_chk("clr_entry", 7'(a), 8'h20);
        end
        check("clr_addr", {25'd0, addr_cnt}, 32'h00);
        check("clr_inc", {31'd0, inc_mode}, 32'd1);

        // 5. Data read of DDRAM[0x02]
        access(1'b0, 8'h82);
        access(1'b1, 8'h67);
        access(1'b0, 8'h82);
        bus_start(1'b1, 1'b1, 8'h00);
        check("rd_dout", {24'd0, lcd_data_out}, 32'h67);
        check("rd_oe", {31'd0, lcd_data_oe}, 32'd1);
        bus_end();
        check("rd_oe_off", {31'd0, lcd_data_oe}, 32'd0);
        check("rd_addr_step", {25'd0, addr_cnt}, 32'h03);
        check("rd_exec_busy", {31'd0, busy}, 32'd1);
        wait_idle("rd_idle");

        // No-op still costs a busy period
        access(1'b0, 8'h00);
        check("nop_addr", {25'd0, addr_cnt}, 32'h03);

        // 6. Invalid DDRAM address, then reset in the middle of a clear
        access(1'b0, 8'hA8);
        check("bad_pulse", bad_cnt, 1);
        check("bad_addr_zero", {25'd0, addr_cnt}, 32'h00);
        bus_start(1'b0, 1'b0, 8'h01);
        bus_end();
        step(40);
        rst = 1'b1;
        step(2);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_CLEAR));
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        count_busy(n);
        check("mid_rst_busy_len", n, 160);
        check("mid_rst_disp", {31'd0, disp_on}, 32'd0);
        check("mid_rst_func", {29'd0, func_bits}, 32'h0);
        check("mid_rst_addr", {25'd0, addr_cnt}, 32'h00);
        rd_chk("mid_rst_02", 7'h02, 8'h20);
        rd_chk("mid_rst_67", 7'h67, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
